ram_cycle_arb: RTL and testbench
================================

Name: ram_cycle_arb

Overview:
- Memory-cycle scheduler for the emulator RAM.
- Consumes the 10-phase active-low timing vector from the clock generator and grants each 10-phase memory cycle to one of three users: refresh, DMA or CPU.
- Drives RAS/CAS/WR strobes, the address mux and the read-data latch, and returns one-cycle acknowledges.
- Sits between the clock generator, the CPU bus interface and the peripheral DMA channel.

Parameters:
- ADDR_W, 16: requester address width.
- DATA_W, 8: data width.
- ROW_W, 7: refresh row counter width; also the low address bits driven during refresh.
- REF_INTERVAL, 16: memory cycles between refresh requests (legal range 2..255).

Ports:
- xtal_in, input, 1: system clock; all state changes on its posedge.
- initn, input, 1: asynchronous active-low reset.
- tn, input, 10 (tn[10:1]): phase vector; phase k is active when tn[k]==0. Normally one-hot-low; all-ones after generator init.
- cpu_req, input, 1: CPU request level.
- cpu_we, input, 1: 1 = write.
- cpu_addr, input, ADDR_W: CPU address.
- cpu_wdata, input, DATA_W: CPU write data.
- dma_req, input, 1: DMA request level.
- dma_we, input, 1: 1 = write.
- dma_addr, input, ADDR_W: DMA address.
- dma_wdata, input, DATA_W: DMA write data.
- ram_rdata, input, DATA_W: RAM data out.
- cpu_ack, output, 1: one-clock pulse; CPU cycle done.
- dma_ack, output, 1: one-clock pulse; DMA cycle done.
- rdata, output, DATA_W: latched read data.
- ram_addr, output, ADDR_W: RAM address.
- ram_wdata, output, DATA_W: RAM write data.
- ram_rasn, output, 1: row strobe, active low.
- ram_casn, output, 1: column strobe, active low.
- ram_wrn, output, 1: write strobe, active low.
- gnt, output, 2: current owner. 00 = idle, 01 = CPU, 10 = DMA, 11 = refresh.

Behaviour:
- **Reset** (initn low, asynchronous):
  - gnt=00.
  - ram_rasn, ram_casn and ram_wrn = 1.
  - cpu_ack and dma_ack = 0.
  - rdata, ram_addr and ram_wdata = 0.
  - Refresh counter, row counter, ref_pend and the round-robin pointer are cleared. The pointer's reset value means CPU wins the first tie.
  - Reset mid-cycle aborts the cycle immediately. No ack is issued and the aborted request is not remembered.
- **Phase events:** all actions below occur on the xtal_in posedge at which the named tn bit is 0. No action is taken while tn is all-ones.
- **Arbitration (phase 1 edge):**
  - If ref_pend: gnt=11 and ref_pend clears. A counter wrap on this same edge sets ref_pend again.
  - Else if dma_req and cpu_req: grant the requester opposite the last CPU/DMA grant (round-robin), then update the pointer.
  - Else grant whichever of dma_req or cpu_req is high; if neither, gnt=00.
  - Latch the owner's address, we and wdata into ram_addr, ram_wdata and an internal we bit. Requester inputs are not sampled again during the cycle.
  - For refresh: ram_addr = {zeros, ref_row}; internal we = 0.
  - Requesters hold req, addr, we and wdata stable from assertion until ack.
- **Strobes** (only when gnt != 00):
  - ram_rasn = 0 at phase 2 edge; ram_rasn = 1 at phase 9 edge.
  - ram_casn = 0 at phase 4 edge and = 1 at phase 9 edge. CPU/DMA cycles only; refresh is RAS-only, so casn stays 1.
  - ram_wrn = 0 at phase 5 edge and = 1 at phase 8 edge. Write cycles only.
- **Read data (phase 8 edge):** on a CPU or DMA read, rdata <= ram_rdata. rdata holds until the next read.
- **Ack (phase 9 edge):** the owner's ack pulses high for exactly one xtal_in cycle. Refresh produces no ack.
- **Cycle end (phase 10 edge):**
  - gnt returns to 00.
  - On a refresh cycle, ref_row increments, wrapping at 2^ROW_W.
  - ref_cnt increments every phase 10 edge. At REF_INTERVAL-1 it wraps to 0 and sets ref_pend.
- **Request repeat:** a req still high at the next phase 1 edge is treated as a new request. Requesters must drop req the clock after ack.
- **Late arrival:** a req asserted after the phase 1 edge waits for the next cycle. Refresh may delay any requester by at most one cycle.
- **Malformed phase vector:** if tn has more than one bit low, actions for every low bit apply, in the priority order above.

Test Plan:
- **Reset to first cycle:** hold initn=0, then release with tn all-ones for 5 clocks → all outputs stay at reset values, gnt=00.
- **CPU read:** cpu_req=1, cpu_we=0, cpu_addr=0x1234, ram_rdata=0x5A → gnt=01 after phase 1; rasn low phases 3–9; casn low phases 5–9; wrn stays 1; rdata=0x5A; single cpu_ack pulse at phase 9.
- **DMA write:** dma_req=1, dma_we=1, addr=0x00FF, wdata=0xC3 → ram_addr=0x00FF; ram_wdata=0xC3; wrn low for phases 6–8 only; one dma_ack.
- **Contention:** cpu_req and dma_req both held continuously for 4 cycles → grants go CPU, DMA, CPU, DMA, one ack per grant.
- **Refresh:** REF_INTERVAL=4 with CPU requesting continuously → every 4th cycle gnt=11, casn stays high, no ack, ram_addr low bits go 0,1,2,…; ROW_W=2 wraps 3→0.
- **Reset mid-cycle:** pull initn low at phase 6 of a CPU write → rasn, casn and wrn return to 1 immediately; no ack; after release with cpu_req still high, a fresh cycle is granted at the next phase 1.

Source files
------------

// File: rtl/ram_cycle_arb.sv
// ram_cycle_arb: 10-phase RAM cycle scheduler.
// Grants each memory cycle to refresh, DMA or CPU.
module ram_cycle_arb #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int ROW_W        = 7,
  parameter int REF_INTERVAL = 16
) (
  input  logic              xtal_in,
  input  logic              initn,
  input  logic [10:1]       tn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              cpu_ack,
  output logic              dma_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_rasn,
  output logic              ram_casn,
  output logic              ram_wrn,
  output logic [1:0]        gnt
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CPU  = 2'b01,
    DMA  = 2'b10,
    REF  = 2'b11
  } own_t;

  localparam logic [7:0] CNT_MAX =
    8'(REF_INTERVAL - 1);

  own_t             state;
  own_t             nxt;
  logic [10:1]      ph;
  logic             ref_pend;
  logic [7:0]       ref_cnt;
  logic [ROW_W-1:0] ref_row;
  logic             ptr;
  logic             we;
  logic             acked;
  logic             busy;
  logic             xfer;
  logic             cnt_wrap;

  assign ph       = ~tn;
  assign busy     = (state != IDLE);
  assign xfer     = (state == CPU) ||
                    (state == DMA);
  assign cnt_wrap = ph[10] &&
                    (ref_cnt == CNT_MAX);
  assign gnt      = state;

  // Owner selection at phase 1, release at phase 10.
  always_comb begin
    nxt = state;
    if (ph[1]) begin
      if (ref_pend)
        nxt = REF;
      else if (cpu_req && dma_req)
        nxt = ptr ? DMA : CPU;
      else if (dma_req)
        nxt = DMA;
      else if (cpu_req)
        nxt = CPU;
      else
        nxt = IDLE;
    end else if (ph[10]) begin
      nxt = IDLE;
    end
  end

  // Owner register.
  always_ff @(posedge xtal_in or negedge initn) begin
    if (!initn)
      state <= IDLE;
    else
      state <= nxt;
  end

  // Refresh interval counter, pending flag and row.
  always_ff @(posedge xtal_in or negedge initn) begin
    if (!initn) begin
      ref_cnt  <= '0;
      ref_pend <= 1'b0;
      ref_row  <= '0;
    end else begin
      if (ph[10])
        ref_cnt <= cnt_wrap ? 8'd0
                            : ref_cnt + 8'd1;
      if (cnt_wrap)
        ref_pend <= 1'b1;
      else if (ph[1] && ref_pend)
        ref_pend <= 1'b0;
      if (ph[10] && state == REF)
        ref_row <= ref_row + 1'b1;
    end
  end

  // Round-robin pointer: 1 means DMA wins a tie.
  always_ff @(posedge xtal_in or negedge initn) begin
    if (!initn)
      ptr <= 1'b0;
    else if (ph[1] && (nxt == CPU || nxt == DMA))
      ptr <= (nxt == CPU);
  end

  // Capture the owner's address, data and direction.
  always_ff @(posedge xtal_in or negedge initn) begin
    if (!initn) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
      we        <= 1'b0;
    end else if (ph[1]) begin
      unique case (nxt)
        CPU: begin
          ram_addr  <= cpu_addr;
          ram_wdata <= cpu_wdata;
          we        <= cpu_we;
        end
        DMA: begin
          ram_addr  <= dma_addr;
          ram_wdata <= dma_wdata;
          we        <= dma_we;
        end
        REF: begin
          ram_addr  <= ADDR_W'(ref_row);
          we        <= 1'b0;
        end
        default: we <= 1'b0;
      endcase
    end
  end

  // RAS/CAS/WR strobe sequencing within the cycle.
  always_ff @(posedge xtal_in or negedge initn) begin
    if (!initn) begin
      ram_rasn <= 1'b1;
      ram_casn <= 1'b1;
      ram_wrn  <= 1'b1;
    end else begin
      if (busy && ph[2])
        ram_rasn <= 1'b0;
      else if (busy && ph[9])
        ram_rasn <= 1'b1;
      if (xfer && ph[4])
        ram_casn <= 1'b0;
      else if (busy && ph[9])
        ram_casn <= 1'b1;
      if (xfer && we && ph[5])
        ram_wrn <= 1'b0;
      else if (busy && ph[8])
        ram_wrn <= 1'b1;
    end
  end

  // Read data latch at phase 8.
  always_ff @(posedge xtal_in or negedge initn) begin
    if (!initn)
      rdata <= '0;
    else if (xfer && !we && ph[8])
      rdata <= ram_rdata;
  end

  // One-clock acknowledge at phase 9.
  always_ff @(posedge xtal_in or negedge initn) begin
    if (!initn) begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      acked   <= 1'b0;
    end else begin
      cpu_ack <= ph[9] && !acked &&
                 (state == CPU);
      dma_ack <= ph[9] && !acked &&
                 (state == DMA);
      if (ph[1])
        acked <= 1'b0;
      else if (ph[9])
        acked <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_cycle_arb.sv
// tb_ram_cycle_arb: directed bench for ram_cycle_arb.
// Small refresh interval and row width exercise wrap.
module tb_ram_cycle_arb;

  localparam int AW = 16;
  localparam int DW = 8;

  logic          xtal_in;
  logic          initn;
  logic [10:1]   tn;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic [DW-1:0] ram_rdata;
  logic          cpu_ack;
  logic          dma_ack;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_rasn;
  logic          ram_casn;
  logic          ram_wrn;
  logic [1:0]    gnt;

  int n_assert;
  int n_fail;

  logic [10:1]   ras_m, cas_m, wr_m;
  logic [10:1]   ca_m, da_m;
  logic [1:0]    g1, g10;
  logic [AW-1:0] a1;
  logic [DW-1:0] d1;

  ram_cycle_arb #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .ROW_W(2),
    .REF_INTERVAL(4)
  ) dut (
    .xtal_in(xtal_in),
    .initn(initn),
    .tn(tn),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .dma_req(dma_req),
    .dma_we(dma_we),
    .dma_addr(dma_addr),
    .dma_wdata(dma_wdata),
    .ram_rdata(ram_rdata),
    .cpu_ack(cpu_ack),
    .dma_ack(dma_ack),
    .rdata(rdata),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rasn(ram_rasn),
    .ram_casn(ram_casn),
    .ram_wrn(ram_wrn),
    .gnt(gnt)
  );

  initial xtal_in = 1'b0;
  always #5 xtal_in = ~xtal_in;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    initn = 1'b0;
    tn    = '1;
    repeat (2) @(posedge xtal_in);
    #1 initn = 1'b1;
    repeat (3) @(posedge xtal_in);
    #1;
  endtask

  task automatic cycle();
    for (int k = 1; k <= 10; k++) begin
      tn = ~(10'd1 << (k - 1));
      @(posedge xtal_in);
      #1;
      ras_m[k] = ram_rasn;
      cas_m[k] = ram_casn;
      wr_m[k]  = ram_wrn;
      ca_m[k]  = cpu_ack;
      da_m[k]  = dma_ack;
      if (k == 1) begin
        g1 = gnt;
        a1 = ram_addr;
        d1 = ram_wdata;
      end
      if (k == 10) g10 = gnt;
    end
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    initn     = 1'b0;
    tn        = '1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    dma_req   = 1'b0;
    dma_we    = 1'b0;
    dma_addr  = '0;
    dma_wdata = '0;
    ram_rdata = 8'h5A;

    repeat (3) @(posedge xtal_in);
    #1;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_rasn", ram_rasn, 1'b1);
    chk("rst_casn", ram_casn, 1'b1);
    chk("rst_wrn", ram_wrn, 1'b1);
    chk("rst_acks", {cpu_ack, dma_ack}, 2'b00);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_addr", ram_addr, 16'h0000);
    chk("rst_wdata", ram_wdata, 8'h00);
    initn = 1'b1;
    repeat (5) @(posedge xtal_in);
    #1;
    chk("idle_gnt", gnt, 2'b00);
    chk("idle_strb",
        {ram_rasn, ram_casn, ram_wrn}, 3'b111);
    chk("idle_addr", ram_addr, 16'h0000);

    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 16'h1234;
    cycle();
    cpu_req = 1'b0;
    chk("rd_gnt", g1, 2'b01);
    chk("rd_addr", a1, 16'h1234);
    chk("rd_ras", ras_m, 10'h301);
    chk("rd_cas", cas_m, 10'h307);
    chk("rd_wr", wr_m, 10'h3FF);
    chk("rd_cack", ca_m, 10'h100);
    chk("rd_dack", da_m, 10'h000);
    chk("rd_data", rdata, 8'h5A);
    chk("rd_end", g10, 2'b00);

    do_reset();
    dma_req   = 1'b1;
    dma_we    = 1'b1;
    dma_addr  = 16'h00FF;
    dma_wdata = 8'hC3;
    cycle();
    dma_req = 1'b0;
    chk("wr_gnt", g1, 2'b10);
    chk("wr_addr", a1, 16'h00FF);
    chk("wr_wdata", d1, 8'hC3);
    chk("wr_ras", ras_m, 10'h301);
    chk("wr_cas", cas_m, 10'h307);
    chk("wr_wr", wr_m, 10'h38F);
    chk("wr_dack", da_m, 10'h100);
    chk("wr_cack", ca_m, 10'h000);
    chk("wr_rdata", rdata, 8'h00);

    do_reset();
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 16'h1111;
    dma_req  = 1'b1;
    dma_we   = 1'b0;
    dma_addr = 16'h2222;
    for (int c = 0; c < 4; c++) begin
      cycle();
      if (c % 2 == 0) begin
        chk("ct_gnt_c", g1, 2'b01);
        chk("ct_addr_c", a1, 16'h1111);
        chk("ct_cack", ca_m, 10'h100);
        chk("ct_dack0", da_m, 10'h000);
      end else begin
        chk("ct_gnt_d", g1, 2'b10);
        chk("ct_addr_d", a1, 16'h2222);
        chk("ct_dack", da_m, 10'h100);
        chk("ct_cack0", ca_m, 10'h000);
      end
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;

    do_reset();
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 16'h4444;
    for (int c = 1; c <= 21; c++) begin
      cycle();
      if (c > 1 && c % 4 == 1) begin
        chk("rf_gnt", g1, 2'b11);
        chk("rf_row", a1,
            32'(((c - 5) / 4) % 4));
        chk("rf_ras", ras_m, 10'h301);
        chk("rf_cas", cas_m, 10'h3FF);
        chk("rf_wr", wr_m, 10'h3FF);
        chk("rf_acks", {ca_m, da_m}, 20'h0);
      end else begin
        chk("rf_cpu_gnt", g1, 2'b01);
        chk("rf_cpu_ack", ca_m, 10'h100);
      end
    end
    cpu_req = 1'b0;

    do_reset();
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 16'h0ABC;
    cpu_wdata = 8'h77;
    for (int k = 1; k <= 6; k++) begin
      tn = ~(10'd1 << (k - 1));
      @(posedge xtal_in);
      #1;
    end
    chk("ab_pre",
        {ram_rasn, ram_casn, ram_wrn}, 3'b000);
    #2 initn = 1'b0;
    #1;
    chk("ab_strb",
        {ram_rasn, ram_casn, ram_wrn}, 3'b111);
    chk("ab_gnt", gnt, 2'b00);
    for (int k = 7; k <= 10; k++) begin
      tn = ~(10'd1 << (k - 1));
      @(posedge xtal_in);
      #1;
      chk("ab_noack", {cpu_ack, dma_ack}, 2'b00);
    end
    tn = '1;
    initn = 1'b1;
    repeat (2) @(posedge xtal_in);
    #1;
    chk("ab_idle", gnt, 2'b00);
    cycle();
    cpu_req = 1'b0;
    chk("ab_gnt2", g1, 2'b01);
    chk("ab_addr2", a1, 16'h0ABC);
    chk("ab_wr2", wr_m, 10'h38F);
    chk("ab_ack2", ca_m, 10'h100);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
